cell_pos_mem_pingpong: RTL

- Parametrised, double-buffered successor to the per-cell position RAM.
- Each cell holds two banks. The active bank serves particle position reads to the force-evaluation pipeline. The shadow bank is filled by the motion-update unit with new positions.
- A single-cycle swap makes the shadow bank active and clears the new shadow.
- The particle count is held in a register per bank, not in RAM. It is still presented at read address 0, so the existing data organisation is kept: address 0 = count, {posz, posy, posx} at addresses 1..N.

---
 rtl/cell_pos_mem_pingpong.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cell_pos_mem_pingpong.sv
// rtl/cell_pos_mem_pingpong.sv - double-buffered per-cell particle position memory
`timescale 1ns/1ps

module cell_pos_mem_pingpong #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 220,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap,
    output logic [CNT_WIDTH-1:0]  active_count,
    output logic [CNT_WIDTH-1:0]  shadow_count,
    output logic                  bank_sel,
    output logic                  overflow
);

    // Address 0 of each bank is the count register, so the RAM only holds
    // particle words 1..DEPTH-1, stored at index addr-1.
    localparam int WORDS = DEPTH - 1;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Common width wide enough to compare an address against a count.
    localparam int CMP_W = ((ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(WORDS);

    logic [DATA_WIDTH-1:0] mem0 [0:WORDS-1];
    logic [DATA_WIDTH-1:0] mem1 [0:WORDS-1];

    // Read decode (cycle T)
    logic [CMP_W-1:0] addr_ext;
    logic [CMP_W-1:0] cnt_ext;
    logic             rd_is_cnt;
    logic             rd_hit;
    logic [IDX_W-1:0] rd_idx;

    // Stage 1 registers
    logic                  s1_valid;
    logic                  s1_is_cnt;
    logic                  s1_hit;
    logic [CNT_WIDTH-1:0]  s1_count;
    logic [DATA_WIDTH-1:0] ram_q;

    // Write / swap control
    logic                 wr_ok;
    logic                 wr_drop;
    logic [IDX_W-1:0]     wr_idx;
    logic [CNT_WIDTH-1:0] cnt_after_wr;

    // Classify the read against the active bank as it stands this cycle;
    // out-of-range addresses read index 0 and are forced to zero later.
    always_comb begin
        addr_ext  = CMP_W'(rd_addr);
        cnt_ext   = CMP_W'(active_count);
        rd_is_cnt = (rd_addr == '0);
        rd_hit    = !rd_is_cnt && (addr_ext <= cnt_ext);
        rd_idx    = '0;
        if (rd_hit) begin
            rd_idx = IDX_W'(rd_addr - ADDR_WIDTH'(1));
        end
    end

    // Append goes to shadow_count+1, i.e. RAM index shadow_count; a full
    // shadow bank drops the word and raises the sticky overflow.
    always_comb begin
        wr_ok        = wr_en && (shadow_count != MAX_CNT);
        wr_drop      = wr_en && (shadow_count == MAX_CNT);
        wr_idx       = IDX_W'(shadow_count);
        cnt_after_wr = shadow_count + CNT_WIDTH'(wr_ok);
    end

    // Shadow-bank write port; the active bank is never written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bank_sel) begin
                mem0[wr_idx] <= wr_data;
            end else begin
                mem1[wr_idx] <= wr_data;
            end
        end
    end

    // Synchronous RAM read from the bank that is active in the request cycle.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q <= bank_sel ? mem1[rd_idx] : mem0[rd_idx];
        end
    end

    // Stage 1 sideband: remember how to form the result and the count snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_is_cnt <= 1'b0;
            s1_hit    <= 1'b0;
            s1_count  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_is_cnt <= rd_is_cnt;
                s1_hit    <= rd_hit;
                s1_count  <= active_count;
            end
        end
    end

    // Output stage: count at address 0, stored word when in range, else zero;
    // rd_data holds its value on cycles with no completing read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_is_cnt) begin
                    rd_data <= DATA_WIDTH'(s1_count);
                end else if (s1_hit) begin
                    rd_data <= ram_q;
                end else begin
                    rd_data <= '0;
                end
            end
        end
    end

    // Bank bookkeeping: a same-cycle write is folded in before the swap so it
    // lands in, and is counted by, the bank that becomes active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel     <= 1'b0;
            active_count <= '0;
            shadow_count <= '0;
            overflow     <= 1'b0;
        end else if (swap) begin
            bank_sel     <= ~bank_sel;
            active_count <= cnt_after_wr;
            shadow_count <= '0;
            overflow     <= 1'b0;
        end else begin
            shadow_count <= cnt_after_wr;
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
